// File: rtl/uart_ldr_pkg.sv
// Shared types and constants for the UART memory loader.
package uart_ldr_pkg;

  // Loader frame-level states.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_BANK,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_RESP,
    ST_FIN
  } ldr_state_t;

  // Receiver bit-level states.
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  // Oversampling ticks per bit and per 8N1 byte.
  localparam int OVS        = 16;
  localparam int BYTE_TICKS = 160;

  // Clock cycles per oversampling tick, rounded to nearest, never below 1.
  function automatic int ldr_div(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + baud * (OVS / 2)) / (baud * OVS);
    if (d < 1) d = 1;
    return d;
  endfunction

endpackage

// File: rtl/uart_ldr_phy.sv
// Serial PHY for the loader: oversampling tick, 8N1 receiver and 8N1 transmitter.
module uart_ldr_phy
  import uart_ldr_pkg::*;
#(
  parameter int CLK_HZ = 23_000_000,
  parameter int BAUD   = 128_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       i_rx,
  output logic       o_tick,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_stb,
  output logic       o_rx_ferr,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx,
  output logic       o_tx_busy
);

  localparam int DIV     = ldr_div(CLK_HZ, BAUD);
  localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_CYC = DIV * OVS;
  localparam int TCW     = $clog2(BIT_CYC);

  logic [DCW-1:0] r_div_cnt;
  logic           w_tick;

  logic           r_rx_meta;
  logic           r_rx_sync;
  rx_state_t      r_rx_state;
  rx_state_t      w_rx_state_next;
  logic [3:0]     r_rx_tcnt;
  logic [2:0]     r_rx_bcnt;
  logic [7:0]     r_rx_shift;
  logic [7:0]     r_rx_byte;
  logic           r_rx_stb;
  logic           r_rx_ferr;

  logic           r_tx_busy;
  logic [9:0]     r_tx_shift;
  logic [3:0]     r_tx_bcnt;
  logic [TCW-1:0] r_tx_ccnt;
  logic           r_tx_line;

  assign w_tick = (r_div_cnt == DCW'(DIV - 1));

  // Free-running divider producing the 16x oversampling tick.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)  r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end

  // Two-flop synchroniser; the line idles high so reset to 1.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver state register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_rx_state <= RX_IDLE;
    else            r_rx_state <= w_rx_state_next;
  end

  // Receiver next state: start confirmed mid-bit, then 8 data bits and one stop bit.
  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_tick && !r_rx_sync) w_rx_state_next = RX_START;
      RX_START: if (w_tick && r_rx_tcnt == 4'd7)
                  w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick && r_rx_tcnt == 4'd15 && r_rx_bcnt == 3'd7)
                  w_rx_state_next = RX_STOP;
      RX_STOP:  if (w_tick && r_rx_tcnt == 4'd15) w_rx_state_next = RX_IDLE;
      default:  w_rx_state_next = RX_IDLE;
    endcase
  end

  // Receiver datapath: tick counting, bit shifting and the byte strobe.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rx_tcnt  <= '0;
      r_rx_bcnt  <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_stb   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_stb <= 1'b0;
      if (w_tick) begin
        case (r_rx_state)
          RX_IDLE: begin
            r_rx_tcnt <= '0;
            r_rx_bcnt <= '0;
          end
          RX_START: r_rx_tcnt <= (r_rx_tcnt == 4'd7) ? 4'd0 : r_rx_tcnt + 1'b1;
          RX_DATA: begin
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
            if (r_rx_tcnt == 4'd15) begin
              r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
              r_rx_bcnt  <= r_rx_bcnt + 1'b1;
            end
          end
          RX_STOP: begin
            r_rx_tcnt <= r_rx_tcnt + 1'b1;
            if (r_rx_tcnt == 4'd15) begin
              r_rx_byte <= r_rx_shift;
              r_rx_stb  <= 1'b1;
              r_rx_ferr <= !r_rx_sync;
            end
          end
          default: r_rx_tcnt <= '0;
        endcase
      end
    end
  end

  // Transmitter: whole bits counted in clock cycles so each lasts exactly one bit time.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_bcnt  <= '0;
      r_tx_ccnt  <= '0;
      r_tx_line  <= 1'b1;
    end else if (!r_tx_busy) begin
      if (i_tx_start) begin
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, i_tx_byte, 1'b0};
        r_tx_line  <= 1'b0;
        r_tx_bcnt  <= '0;
        r_tx_ccnt  <= '0;
      end
    end else if (r_tx_ccnt == TCW'(BIT_CYC - 1)) begin
      r_tx_ccnt <= '0;
      if (r_tx_bcnt == 4'd9) begin
        r_tx_busy <= 1'b0;
        r_tx_line <= 1'b1;
      end else begin
        r_tx_bcnt  <= r_tx_bcnt + 1'b1;
        r_tx_line  <= r_tx_shift[1];
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      end
    end else begin
      r_tx_ccnt <= r_tx_ccnt + 1'b1;
    end
  end

  assign o_tick    = w_tick;
  assign o_rx_byte = r_rx_byte;
  assign o_rx_stb  = r_rx_stb;
  assign o_rx_ferr = r_rx_ferr;
  assign o_tx      = r_tx_line;
  assign o_tx_busy = r_tx_busy;

endmodule

// File: rtl/uart_mem_loader.sv
// Framed UART image loader: parses header/bank/length/payload/checksum and writes words to a bank.
module uart_mem_loader
  import uart_ldr_pkg::*;
#(
  parameter int CLK_HZ        = 23_000_000,
  parameter int BAUD          = 128_000,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 14,
  parameter int N_BANKS       = 2,
  parameter int TIMEOUT_BYTES = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               start_i,
  input  logic               rx_i,
  output logic               tx_o,
  output logic [N_BANKS-1:0] wen_o,
  output logic [ADDR_W-1:0]  adr_o,
  output logic [DATA_W-1:0]  dat_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  localparam int BPW      = DATA_W / 8;
  localparam int BCW      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int BKW      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
  localparam int TO_TICKS = TIMEOUT_BYTES * BYTE_TICKS;
  localparam int TOW      = $clog2(TO_TICKS + 1);
  localparam logic [32:0] MAX_LEN = 33'(1) << ADDR_W;

  // PHY interface
  logic              w_tick;
  logic [7:0]        w_rx_byte;
  logic              w_rx_stb;
  logic              w_rx_ferr;
  logic              w_tx_start;
  logic [7:0]        w_tx_byte;
  logic              w_tx_line;
  logic              w_tx_busy;

  // FSM
  ldr_state_t        r_state;
  ldr_state_t        w_state_next;
  logic              w_pass;
  logic              w_fail;
  logic              w_busy;

  // Datapath registers
  logic              r_start_d;
  logic              r_resp_sent;
  logic              r_done;
  logic              r_err;
  logic [BKW-1:0]    r_bank;
  logic [15:0]       r_len;
  logic [DATA_W-1:0] r_word;
  logic [BCW-1:0]    r_byte_cnt;
  logic [ADDR_W:0]   r_word_idx;
  logic [7:0]        r_csum;
  logic [TOW-1:0]    r_to_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [N_BANKS-1:0] r_wen;

  // Decode helpers
  logic              w_start_rise;
  logic              w_in_frame;
  logic              w_timeout;
  logic              w_byte_ok;
  logic              w_byte_bad;
  logic [15:0]       w_len_full;
  logic              w_word_last;
  logic [ADDR_W:0]   w_idx_inc;
  logic              w_words_done;
  logic [DATA_W-1:0] w_word_shift;
  logic              w_word_wr;

  uart_ldr_phy #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_phy (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .i_rx       (rx_i),
    .o_tick     (w_tick),
    .o_rx_byte  (w_rx_byte),
    .o_rx_stb   (w_rx_stb),
    .o_rx_ferr  (w_rx_ferr),
    .i_tx_start (w_tx_start),
    .i_tx_byte  (w_tx_byte),
    .o_tx       (w_tx_line),
    .o_tx_busy  (w_tx_busy)
  );

  assign w_start_rise = start_i & ~r_start_d;
  assign w_in_frame   = r_state inside {ST_BANK, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
  assign w_timeout    = w_in_frame && (r_to_cnt >= TOW'(TO_TICKS));
  assign w_byte_ok    = w_rx_stb && !w_rx_ferr;
  assign w_byte_bad   = w_rx_stb && w_rx_ferr;
  assign w_len_full   = {w_rx_byte, r_len[7:0]};
  assign w_word_last  = (r_byte_cnt == BCW'(BPW - 1));
  assign w_idx_inc    = r_word_idx + 1'b1;
  assign w_words_done = (33'(w_idx_inc) == 33'(r_len));
  // Little-endian assembly: the newest byte enters at the top and slides down.
  assign w_word_shift = (r_word >> 8) | (DATA_W'(w_rx_byte) << (DATA_W - 8));
  assign w_word_wr    = (r_state == ST_DATA) && w_byte_ok && w_word_last;

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  // FSM next state; framing errors and timeouts abort any in-frame state, a byte beats a timeout.
  always_comb begin
    w_state_next = r_state;
    w_pass       = 1'b0;
    w_fail       = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start_rise) w_state_next = ST_HDR;
      ST_HDR:  if (w_byte_ok && w_rx_byte == HDR_BYTE) w_state_next = ST_BANK;
      ST_BANK: if (w_byte_ok) begin
                 if (w_rx_byte >= 8'(N_BANKS)) w_fail = 1'b1;
                 else                          w_state_next = ST_LEN0;
               end
      ST_LEN0: if (w_byte_ok) w_state_next = ST_LEN1;
      ST_LEN1: if (w_byte_ok) begin
                 if (33'(w_len_full) > MAX_LEN) w_fail = 1'b1;
                 else if (w_len_full == 16'd0)  w_state_next = ST_CSUM;
                 else                           w_state_next = ST_DATA;
               end
      ST_DATA: if (w_word_wr && w_words_done) w_state_next = ST_CSUM;
      ST_CSUM: if (w_byte_ok) begin
                 if (w_rx_byte == r_csum) w_pass = 1'b1;
                 else                     w_fail = 1'b1;
               end
      ST_RESP: if (r_resp_sent && !w_tx_busy) w_state_next = ST_FIN;
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_in_frame && (w_byte_bad || (!w_rx_stb && w_timeout))) w_fail = 1'b1;
    if (w_pass || w_fail) w_state_next = ST_RESP;
  end

  // FSM outputs: busy span, single TX launch in RESP, ACK/NAK choice.
  always_comb begin
    w_busy     = !(r_state inside {ST_IDLE, ST_FIN});
    w_tx_start = (r_state == ST_RESP) && !r_resp_sent;
    w_tx_byte  = r_done ? ACK : NAK;
  end

  // Frame datapath: flags, length, checksum, word assembly and timeout counter.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_start_d   <= 1'b0;
      r_resp_sent <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_bank      <= '0;
      r_len       <= '0;
      r_word      <= '0;
      r_byte_cnt  <= '0;
      r_word_idx  <= '0;
      r_csum      <= '0;
      r_to_cnt    <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
    end else begin
      r_start_d   <= start_i;
      r_resp_sent <= (r_state == ST_RESP);

      if (!w_in_frame || w_rx_stb)                     r_to_cnt <= '0;
      else if (w_tick && r_to_cnt < TOW'(TO_TICKS))    r_to_cnt <= r_to_cnt + 1'b1;

      if (r_state == ST_IDLE && w_start_rise) begin
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_byte_cnt <= '0;
        r_word_idx <= '0;
        r_csum     <= '0;
      end
      if (w_pass) r_done <= 1'b1;
      if (w_fail) r_err  <= 1'b1;

      if (w_byte_ok) begin
        case (r_state)
          ST_BANK: r_bank <= w_rx_byte[BKW-1:0];
          ST_LEN0: r_len[7:0]  <= w_rx_byte;
          ST_LEN1: r_len[15:8] <= w_rx_byte;
          ST_DATA: begin
            r_word <= w_word_shift;
            r_csum <= r_csum ^ w_rx_byte;
            if (w_word_last) begin
              r_byte_cnt <= '0;
              r_word_idx <= w_idx_inc;
              r_adr      <= r_word_idx[ADDR_W-1:0];
              r_dat      <= w_word_shift;
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // One write-enable flop per bank, pulsing for the cycle after a word completes.
  for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_wen
    // Bank gi enable: set only when the selected bank matches this lane.
    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) r_wen[gi] <= 1'b0;
      else            r_wen[gi] <= w_word_wr && (r_bank == BKW'(gi));
    end
  end

  assign tx_o   = w_tx_line;
  assign wen_o  = r_wen;
  assign adr_o  = r_adr;
  assign dat_o  = r_dat;
  assign busy_o = w_busy;
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: frames in over rx_i, writes and ACK/NAK checked.
module tb_uart_mem_loader;

  // 4.096 MHz / (128k*16) gives 2 clocks per tick, 32 clocks per bit.
  localparam int BIT_CYC = 32;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [47:0] wr_q_t[$];

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start_i   = 1'b0;
  logic        rx_i      = 1'b1;
  logic        tx_o;
  logic [1:0]  wen_o;
  logic [13:0] adr_o;
  logic [31:0] dat_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int          total = 0;
  int          bad   = 0;
  int          long_wen = 0;
  logic        prev_wen = 1'b0;
  wr_q_t       wq;
  byte_q_t     txq;
  logic [7:0]  tx_b;
  byte_q_t     fr;
  wr_q_t       ew;

  uart_mem_loader #(
    .CLK_HZ        (4_096_000),
    .BAUD          (128_000),
    .DATA_W        (32),
    .ADDR_W        (14),
    .N_BANKS       (2),
    .TIMEOUT_BYTES (64)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start_i   (start_i),
    .rx_i      (rx_i),
    .tx_o      (tx_o),
    .wen_o     (wen_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Record every write cycle and flag enables that stay high more than one cycle.
  always @(negedge sys_clk) begin
    if (wen_o != 2'b00) wq.push_back({wen_o, adr_o, dat_o});
    if (wen_o != 2'b00 && prev_wen) long_wen <= long_wen + 1;
    prev_wen <= (wen_o != 2'b00);
  end

  // Decode 8N1 bytes on tx_o by sampling mid-bit.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (tx_o === 1'b0) begin
        repeat (BIT_CYC / 2) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(negedge sys_clk);
          tx_b[i] = tx_o;
        end
        repeat (BIT_CYC) @(negedge sys_clk);
        txq.push_back(tx_b);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_i = 1'b0;
    repeat (BIT_CYC) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT_CYC) @(negedge sys_clk);
    end
    rx_i = 1'b1;
    repeat (BIT_CYC) @(negedge sys_clk);
  endtask

  task automatic send_bytes(input byte_q_t bs);
    foreach (bs[i]) send_byte(bs[i]);
  endtask

  task automatic arm();
    @(negedge sys_clk);
    start_i = 1'b1;
    @(negedge sys_clk);
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy_o && n < max_cyc) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_busy_drop"}, 64'(busy_o), 64'd0);
  endtask

  task automatic check_resp(input string tag, input logic d, input logic e, input logic [7:0] rsp);
    chk({tag, "_done"}, 64'(done_o), 64'(d));
    chk({tag, "_err"},  64'(err_o),  64'(e));
    chk({tag, "_ntx"},  64'(txq.size()), 64'd1);
    if (txq.size() > 0) chk({tag, "_txbyte"}, 64'(txq[0]), 64'(rsp));
    txq.delete();
  endtask

  task automatic check_writes(input string tag, input wr_q_t exp);
    chk({tag, "_nwr"}, 64'(wq.size()), 64'(exp.size()));
    foreach (exp[i])
      if (i < wq.size()) chk($sformatf("%s_wr%0d", tag, i), 64'(wq[i]), 64'(exp[i]));
    wq.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_wen",  64'(wen_o),  64'd0);
    chk("rst_adr",  64'(adr_o),  64'd0);
    chk("rst_dat",  64'(dat_o),  64'd0);
    chk("rst_tx",   64'(tx_o),   64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err",  64'(err_o),  64'd0);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // Good two-word frame to bank 1, checksum 0x66
    arm();
    chk("t1_busy_arm", 64'(busy_o), 64'd1);
    fr = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
    send_bytes(fr);
    wait_idle("t1", 2000);
    ew = '{{2'b10, 14'd0, 32'h11223344}, {2'b10, 14'd1, 32'hDEADBEEF}};
    check_writes("t1", ew);
    check_resp("t1", 1'b1, 1'b0, 8'h06);

    // Same frame, checksum off by one; re-arm clears done
    arm();
    chk("t2_done_clr", 64'(done_o), 64'd0);
    fr[12] = 8'h67;
    send_bytes(fr);
    wait_idle("t2", 2000);
    check_writes("t2", ew);
    check_resp("t2", 1'b0, 1'b1, 8'h15);

    // Bank out of range
    arm();
    fr = '{8'hA5, 8'h05};
    send_bytes(fr);
    wait_idle("t3", 2000);
    ew = '{};
    check_writes("t3", ew);
    check_resp("t3", 1'b0, 1'b1, 8'h15);

    // Noise before header, then LEN=0 with CSUM 0
    arm();
    fr = '{8'h00, 8'h7F, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_bytes(fr);
    wait_idle("t4", 2000);
    check_writes("t4", ew);
    check_resp("t4", 1'b1, 1'b0, 8'h06);

    // LEN = 2^14 + 1 is one beyond the bank
    arm();
    fr = '{8'hA5, 8'h00, 8'h01, 8'h40};
    send_bytes(fr);
    wait_idle("t5", 2000);
    check_writes("t5", ew);
    check_resp("t5", 1'b0, 1'b1, 8'h15);

    // Byte flow stops after 3 payload bytes: timeout after 64 byte times
    arm();
    fr = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
    send_bytes(fr);
    repeat (200) @(negedge sys_clk);
    chk("t6_still_busy", 64'(busy_o), 64'd1);
    wait_idle("t6", 25000);
    check_writes("t6", ew);
    check_resp("t6", 1'b0, 1'b1, 8'h15);

    // Reset mid-frame after one word to bank 0
    arm();
    fr = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA};
    send_bytes(fr);
    ew = '{{2'b01, 14'd0, 32'h11223344}};
    check_writes("t7", ew);
    sys_rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("t7_rst_wen",  64'(wen_o),  64'd0);
    chk("t7_rst_adr",  64'(adr_o),  64'd0);
    chk("t7_rst_dat",  64'(dat_o),  64'd0);
    chk("t7_rst_tx",   64'(tx_o),   64'd1);
    chk("t7_rst_busy", 64'(busy_o), 64'd0);
    chk("t7_rst_done", 64'(done_o), 64'd0);
    chk("t7_rst_err",  64'(err_o),  64'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    chk("t7_idle", 64'(busy_o), 64'd0);

    // start_i pulse mid-transfer is ignored
    arm();
    fr = '{8'hA5, 8'h01, 8'h01, 8'h00};
    send_bytes(fr);
    arm();
    fr = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    send_bytes(fr);
    wait_idle("t8", 2000);
    ew = '{{2'b10, 14'd0, 32'h04030201}};
    check_writes("t8", ew);
    check_resp("t8", 1'b1, 1'b0, 8'h06);

    // New arm after FIN clears done and raises busy
    arm();
    chk("t9_done_clr", 64'(done_o), 64'd0);
    chk("t9_busy",     64'(busy_o), 64'd1);

    chk("wen_single_cycle", 64'(long_wen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
